// File: rtl/cr_cp0_srst_mc.sv
// cr_cp0_srst_mc: CP0 soft-reset sequencer. Collects quiesce acks from all channels,
// drives the latched reset type to system IO for HOLD_CYC cycles, then parks until reset.
//
// Ports:
//   srst_sm_clk        in   clock
//   rst                in   asynchronous active-high reset
//   ex_sel             in   soft-reset instruction in execute stage
//   flush              in   pipeline flush (aborts only while waiting for acks)
//   req_valid          in   soft-reset request
//   req_valid_noinput  in   timing-relaxed copy of req_valid, used only for iui_stall_noinput
//   srst_value         in   [SRST_W]  requested reset type
//   srst_ack           in   [ACK_NUM] per-channel quiesce ack
//   srst_req           out  [ACK_NUM] per-channel quiesce request
//   sysio_srst         out  [SRST_W]  reset request to system IO
//   ifu_mask           out  fetch mask
//   iui_stall          out  issue stall
//   iui_stall_noinput  out  issue stall from the relaxed request copy
//   sm_clk_en          out  gated-clock enable for this block
//   timeout            out  sticky ack-timeout flag (only with SRST_TIMEOUT_EN)
//
// Build option: define SRST_TIMEOUT_EN to bound the ack wait with a TO_W-bit counter.
module cr_cp0_srst_mc #(
    parameter int ACK_NUM  = 2,
    parameter int SRST_W   = 2,
    parameter int HOLD_CYC = 1,
    parameter int TO_W     = 8
) (
    input  logic               srst_sm_clk,
    input  logic               rst,
    input  logic               ex_sel,
    input  logic               flush,
    input  logic               req_valid,
    input  logic               req_valid_noinput,
    input  logic [SRST_W-1:0]  srst_value,
    input  logic [ACK_NUM-1:0] srst_ack,
    output logic [ACK_NUM-1:0] srst_req,
    output logic [SRST_W-1:0]  sysio_srst,
    output logic               ifu_mask,
    output logic               iui_stall,
    output logic               iui_stall_noinput,
    output logic               sm_clk_en
`ifdef SRST_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    if (ACK_NUM < 1 || ACK_NUM > 8 || SRST_W < 1 || SRST_W > 4 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 || TO_W < 1 || TO_W > 31) begin : g_bad_param
        $error("cr_cp0_srst_mc: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WFACK, HOLD, WFRST} state_t;

    state_t             state;
    logic [SRST_W-1:0]  value;
    logic [ACK_NUM-1:0] sticky;
    logic [3:0]         hold_cnt;
    logic               idle;
    logic               acks_done;
    logic               to_hit;

    assign idle      = state == IDLE;
    // the last ack may arrive in the very cycle the set completes
    assign acks_done = &(sticky | srst_ack);

`ifdef SRST_TIMEOUT_EN
    // leaving on the edge that makes the counter all-ones
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((64'd1 << TO_W) - 64'd2);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = to_cnt == TO_LAST;

    always_ff @(posedge srst_sm_clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            to_cnt <= (state == WFACK && !flush) ? to_cnt + 1'b1 : '0;
            if (state == WFACK && !flush && to_hit && !acks_done)
                timeout <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge srst_sm_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            value    <= '0;
            sticky   <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state  <= WFACK;
                    value  <= srst_value;
                    sticky <= '0;
                end
                WFACK: if (flush) begin
                    state    <= IDLE;
                    sticky   <= '0;
                    hold_cnt <= '0;
                end else begin
                    sticky <= sticky | srst_ack;
                    if (acks_done || to_hit) begin
                        state    <= HOLD;
                        hold_cnt <= 4'(HOLD_CYC - 1);
                    end
                end
                HOLD: if (hold_cnt == 4'd0) state <= WFRST;
                      else hold_cnt <= hold_cnt - 4'd1;
                WFRST: state <= WFRST;
            endcase
        end
    end

    // outputs decode the async-reset state, so they drop the moment rst rises
    assign srst_req          = (state == WFACK) ? ~sticky : '0;
    assign sysio_srst        = (state == HOLD) ? value : '0;
    assign ifu_mask          = state == HOLD || state == WFRST;
    assign iui_stall         = !rst && (req_valid || !idle);
    assign iui_stall_noinput = !rst && (req_valid_noinput || !idle);
    assign sm_clk_en         = ex_sel || !idle;

endmodule

// File: tb/tb_cr_cp0_srst_mc.sv
// tb_cr_cp0_srst_mc: checks two sequencer configurations against a behavioural model.
module tb_cr_cp0_srst_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_sel = 1'b0, flush = 1'b0, req_valid = 1'b0, req_valid_nq = 1'b0;
    logic [1:0] val = '0, ack0 = '0;
    logic [2:0] ack1 = '0;
    logic [1:0] req0, sys0, sys1;
    logic [2:0] req1;
    logic       ifu0, st0, stn0, ce0, ifu1, st1, stn1, ce1;
`ifdef SRST_TIMEOUT_EN
    logic       to0, to1;
`endif

    int tests = 0;
    int errors = 0;

    localparam int NA [2] = '{2, 3};
    localparam int NH [2] = '{1, 3};
    localparam int NT [2] = '{8, 4};

    // model: 0 idle, 1 collecting acks, 2 asserting reset, 3 parked
    int m_mode [2];
    int m_got  [2];
    int m_left [2];
    int m_val  [2];
    int m_wait [2];
    bit m_to   [2];

    always #5 clk = ~clk;

    cr_cp0_srst_mc u0 (
        .srst_sm_clk(clk), .rst(rst), .ex_sel(ex_sel), .flush(flush),
        .req_valid(req_valid), .req_valid_noinput(req_valid_nq),
        .srst_value(val), .srst_ack(ack0), .srst_req(req0), .sysio_srst(sys0),
        .ifu_mask(ifu0), .iui_stall(st0), .iui_stall_noinput(stn0), .sm_clk_en(ce0)
`ifdef SRST_TIMEOUT_EN
        , .timeout(to0)
`endif
    );

    cr_cp0_srst_mc #(.ACK_NUM(3), .SRST_W(2), .HOLD_CYC(3), .TO_W(4)) u1 (
        .srst_sm_clk(clk), .rst(rst), .ex_sel(ex_sel), .flush(flush),
        .req_valid(req_valid), .req_valid_noinput(req_valid_nq),
        .srst_value(val), .srst_ack(ack1), .srst_req(req1), .sysio_srst(sys1),
        .ifu_mask(ifu1), .iui_stall(st1), .iui_stall_noinput(stn1), .sm_clk_en(ce1)
`ifdef SRST_TIMEOUT_EN
        , .timeout(to1)
`endif
    );

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            int ackv, full;
            full = (1 << NA[k]) - 1;
            ackv = (k == 0) ? int'(ack0) : int'(ack1);
            if (rst) begin
                m_mode[k] = 0; m_got[k] = 0; m_left[k] = 0; m_val[k] = 0; m_wait[k] = 0; m_to[k] = 1'b0;
            end else if (m_mode[k] == 0) begin
                if (req_valid) begin
                    m_mode[k] = 1; m_got[k] = 0; m_val[k] = int'(val); m_wait[k] = 0;
                end
            end else if (m_mode[k] == 1) begin
                if (flush) begin
                    m_mode[k] = 0; m_got[k] = 0;
                end else begin
                    m_got[k] = m_got[k] | ackv;
                    m_wait[k] = m_wait[k] + 1;
                    if (m_got[k] == full) begin
                        m_mode[k] = 2; m_left[k] = NH[k];
                    end
`ifdef SRST_TIMEOUT_EN
                    else if (m_wait[k] == (1 << NT[k]) - 1) begin
                        m_mode[k] = 2; m_left[k] = NH[k]; m_to[k] = 1'b1;
                    end
`endif
                end
            end else if (m_mode[k] == 2) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) m_mode[k] = 3;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            int full;
            full = (1 << NA[k]) - 1;
            cmp($sformatf("u%0d srst_req", k), k == 0 ? int'(req0) : int'(req1),
                m_mode[k] == 1 ? (~m_got[k] & full) : 0);
            cmp($sformatf("u%0d sysio_srst", k), k == 0 ? int'(sys0) : int'(sys1),
                m_mode[k] == 2 ? m_val[k] : 0);
            cmp($sformatf("u%0d ifu_mask", k), k == 0 ? int'(ifu0) : int'(ifu1),
                m_mode[k] >= 2 ? 1 : 0);
            cmp($sformatf("u%0d iui_stall", k), k == 0 ? int'(st0) : int'(st1),
                (!rst && (m_mode[k] != 0 || req_valid)) ? 1 : 0);
            cmp($sformatf("u%0d iui_stall_noinput", k), k == 0 ? int'(stn0) : int'(stn1),
                (!rst && (m_mode[k] != 0 || req_valid_nq)) ? 1 : 0);
            cmp($sformatf("u%0d sm_clk_en", k), k == 0 ? int'(ce0) : int'(ce1),
                (ex_sel || m_mode[k] != 0) ? 1 : 0);
`ifdef SRST_TIMEOUT_EN
            cmp($sformatf("u%0d timeout", k), k == 0 ? int'(to0) : int'(to1), int'(m_to[k]));
`endif
        end
    endtask

    task automatic step(input logic rv, input logic [1:0] v, input logic [1:0] a0,
                        input logic [2:0] a1, input logic fl);
        req_valid = rv; req_valid_nq = rv; val = v; ack0 = a0; ack1 = a1; flush = fl;
        #1;
    endtask

    task automatic advance();
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ex_sel = 1'b0;
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0); advance();
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0); advance();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rv;
        logic [1:0] v;
        logic [1:0] a;
        logic       fl;
        logic [1:0] e_req;
        logic [1:0] e_sys;
        logic       e_ifu;
        logic       e_st;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 2'b00, 2'b11, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};

        // outputs held low in reset, clock enable follows ex_sel
        @(negedge clk);
        ex_sel = 1'b1;
        step(1'b1, 2'b11, 2'b11, 3'b111, 1'b0);
        cmp("rst iui_stall", int'(st0), 0);
        cmp("rst iui_stall_noinput", int'(stn1), 0);
        cmp("rst srst_req", int'(req1), 0);
        cmp("rst sysio_srst", int'(sys0), 0);
        cmp("rst ifu_mask", int'(ifu0), 0);
        cmp("rst sm_clk_en hi", int'(ce0), 1);
        ex_sel = 1'b0; #1;
        cmp("rst sm_clk_en lo", int'(ce1), 0);
        advance();
        do_reset();

        // two acks together, one-cycle hold of 2'b10
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rv, tbl[i].v, tbl[i].a, 3'b000, tbl[i].fl);
            cmp($sformatf("vec%0d srst_req", i), int'(req0), int'(tbl[i].e_req));
            cmp($sformatf("vec%0d sysio_srst", i), int'(sys0), int'(tbl[i].e_sys));
            cmp($sformatf("vec%0d ifu_mask", i), int'(ifu0), int'(tbl[i].e_ifu));
            cmp($sformatf("vec%0d iui_stall", i), int'(st0), int'(tbl[i].e_st));
            advance();
        end

        // three acks on WFACK cycles 2, 5, 7, then a flush ignored during a 3-cycle hold
        do_reset();
        step(1'b1, 2'b01, 2'b00, 3'b000, 1'b0); advance();
        for (int c = 1; c <= 11; c++) begin
            step(1'b0, 2'b00, 2'b00, c == 2 ? 3'b001 : c == 5 ? 3'b010 : c == 7 ? 3'b100 : 3'b000,
                 c == 9);
            cmp($sformatf("seq3 c%0d srst_req", c), int'(req1), c <= 2 ? 7 : c <= 5 ? 6 : c <= 7 ? 4 : 0);
            cmp($sformatf("seq3 c%0d sysio_srst", c), int'(sys1), (c >= 8 && c <= 10) ? 1 : 0);
            cmp($sformatf("seq3 c%0d ifu_mask", c), int'(ifu1), c >= 8 ? 1 : 0);
            advance();
        end

        // flush with a partial ack set forgets it
        do_reset();
        step(1'b1, 2'b11, 2'b00, 3'b000, 1'b0); advance();
        step(1'b0, 2'b00, 2'b01, 3'b000, 1'b0); cmp("flush req a", int'(req0), 3); advance();
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b1); cmp("flush req b", int'(req0), 2); advance();
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0); cmp("flush req c", int'(req0), 0);
        cmp("flush idle stall", int'(st0), 0); advance();
        step(1'b1, 2'b11, 2'b00, 3'b000, 1'b0); advance();
        step(1'b0, 2'b00, 2'b10, 3'b000, 1'b0); cmp("rereq both", int'(req0), 3); advance();
        step(1'b0, 2'b00, 2'b01, 3'b000, 1'b0); cmp("rereq one", int'(req0), 1); advance();
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0); cmp("rereq hold", int'(sys0), 3); advance();

        // reset mid-hold takes effect without a clock edge
        do_reset();
        step(1'b1, 2'b10, 2'b00, 3'b000, 1'b0); advance();
        step(1'b0, 2'b00, 2'b11, 3'b111, 1'b0); advance();
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0);
        cmp("pre-rst sysio_srst", int'(sys1), 2);
        cmp("pre-rst ifu_mask", int'(ifu1), 1);
        #2 rst = 1'b1;
        #1;
        cmp("async sysio_srst", int'(sys1), 0);
        cmp("async srst_req", int'(req1), 0);
        cmp("async ifu_mask", int'(ifu1), 0);
        cmp("async iui_stall", int'(st1), 0);
        advance();
        rst = 1'b0;
        step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0);
        cmp("post-rst iui_stall", int'(st1), 0);
        cmp("post-rst ifu_mask", int'(ifu1), 0);
        advance();

`ifdef SRST_TIMEOUT_EN
        // no acks: 15 WFACK cycles then forced hold with timeout
        do_reset();
        step(1'b1, 2'b01, 2'b00, 3'b000, 1'b0); advance();
        for (int c = 1; c <= 17; c++) begin
            step(1'b0, 2'b00, 2'b00, 3'b000, 1'b0);
            if (c == 15) cmp("to last wait", int'(req1), 7);
            if (c == 16) begin
                cmp("to hold", int'(sys1), 1);
                cmp("to flag", int'(to1), 1);
            end
            advance();
        end
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 59) == 0;
            ex_sel = 1'($urandom);
            req_valid = $urandom_range(0, 3) == 0;
            req_valid_nq = 1'($urandom);
            val = 2'($urandom);
            flush = $urandom_range(0, 7) == 0;
            for (int b = 0; b < 2; b++) ack0[b] = $urandom_range(0, 3) == 0;
            for (int b = 0; b < 3; b++) ack1[b] = $urandom_range(0, 3) == 0;
            #1;
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
